// File: rtl/inst_rom_sync_if.sv
// Fetch bus between the PC/fetch stage (master) and the instruction memory
// (slave): a valid/ready request channel carrying a byte address, a
// valid/ready response channel carrying the instruction word and an
// out-of-range flag, and a redirect flush.
interface inst_rom_sync_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              flush;

  modport master (
    output req_valid, req_addr, rsp_ready, flush,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/inst_rom_sync.sv
// Synchronous instruction memory with a 1- or 2-stage registered read
// pipeline, valid/ready backpressure, redirect flush and out-of-range
// detection (out-of-range fetches return the all-zero halt word with
// rsp_err set).
//
// Optional feature macro: INST_ROM_LOAD_EN
//   defined   -> ld_we/ld_addr/ld_data write the memory at run time
//   undefined -> memory is read-only; the loader ports are accepted but
//                ignored.
//
// The bus interface instance must be built with the same DATA_W/ADDR_W as
// this module.
module inst_rom_sync #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  inst_rom_sync_if.slave           bus,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data
);

  localparam int IDX_W = $clog2(DEPTH);

  // Legal configurations only; anything else is an elaboration error.
  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("inst_rom_sync: LATENCY must be 1 or 2");
  end
  if (DEPTH < 32 || DEPTH > 4096 || (1 << IDX_W) != DEPTH) begin : g_bad_depth
    $error("inst_rom_sync: DEPTH must be a power of two in 32..4096");
  end
  if (ADDR_W <= IDX_W + 2) begin : g_bad_addr_w
    $error("inst_rom_sync: ADDR_W too narrow for DEPTH");
  end

  // One pipeline slot: response valid, out-of-range flag and word.
  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } stage_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  stage_t            s1_q;
  stage_t            last_s;
  logic              adv;
  logic              accept;
  logic              oor;
  logic [IDX_W-1:0]  idx;
  logic              unused_addr_bits;

  // Word index from the byte address; the byte-offset bits are don't-care.
  assign idx              = bus.req_addr[IDX_W+1:2];
  assign unused_addr_bits = ^bus.req_addr[1:0];
  assign oor              = |bus.req_addr[ADDR_W-1:IDX_W+2];

  // The whole pipeline moves unless the output holds a response that the
  // consumer is refusing. Stall-to-ready is therefore purely combinational.
  assign adv           = !(last_s.valid && !bus.rsp_ready);
  assign bus.req_ready = adv && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  // Memory initialisation: all words start at zero.
  // NOTE: the memory has no reset; contents survive rst so a program loaded
  // once stays valid across CPU resets (and a resettable array would not map
  // onto block RAM).
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  // Stage 1: registered memory read; out-of-range fetches become the halt word.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values; this is also what gives read-before-write
  // against the loader port.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else if (bus.flush) begin
      s1_q.valid <= 1'b0;
    end else if (adv) begin
      s1_q.valid <= accept;
      s1_q.err   <= oor;
      s1_q.data  <= oor ? '0 : mem_q[idx];
    end
  end

  if (LATENCY == 2) begin : g_lat2
    stage_t s2_q;

    // Stage 2: follows stage 1 whenever the pipeline advances.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_q <= '0;
      end else if (bus.flush) begin
        s2_q.valid <= 1'b0;
      end else if (adv) begin
        s2_q <= s1_q;
      end
    end

    assign last_s = s2_q;
  end else begin : g_lat1
    assign last_s = s1_q;
  end

  assign bus.rsp_valid = last_s.valid;
  assign bus.rsp_data  = last_s.data;
  assign bus.rsp_err   = last_s.err;

`ifdef INST_ROM_LOAD_EN
  // Run-time loader: independent of the fetch handshake and of stalls;
  // suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && ld_we) begin
      mem_q[ld_addr] <= ld_data;
    end
  end
`else
  logic unused_ld;
  assign unused_ld = ^{ld_we, ld_addr, ld_data};
`endif

endmodule

// File: tb/tb_inst_rom_sync.sv
// Directed bench for inst_rom_sync: one LATENCY=1 and one LATENCY=2 instance
// side by side, sharing clock, reset and loader inputs. Inputs change 1 ns
// after the rising edge and outputs are sampled 1 ns later.
module tb_inst_rom_sync;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_we = 1'b0;
  logic [5:0]        ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;

  logic [DATA_W-1:0] model [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  inst_rom_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b1 ();
  inst_rom_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b2 ();

  inst_rom_sync #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(1), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  inst_rom_sync #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(2), .INIT_FILE("")
  ) dut2 (
    .clk(clk), .rst(rst), .bus(b2),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streaming vectors for the LATENCY=1 instance: address and expected response.
  logic [31:0] s_addr [8];
  logic [31:0] s_data [8];
  logic        s_err  [8];

  // Backpressure table for the LATENCY=2 instance, one entry per cycle.
  logic bp_rsp_ready [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic bp_exp_rv    [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic bp_exp_rr    [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int   bp_exp_word  [10] = '{-1, -1, 4, 5, 5, 5, 5, 6, 7, -1};

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_new;
    int          sent;

    for (int i = 0; i < DEPTH; i++) model[i] = 32'hC0DE_0000 | i;
    model[0] = 32'h3463_0010;
    model[1] = 32'hac03_0000;

    s_addr = '{32'h0, 32'h4, 32'h100, 32'h8, 32'h7, 32'hFC, 32'h8000_0000, 32'h14};
    s_data = '{32'h3463_0010, 32'hac03_0000, 32'h0, model[2], 32'hac03_0000,
               model[63], 32'h0, model[5]};
    s_err  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    b1.req_valid = 1'b0; b1.req_addr = '0; b1.rsp_ready = 1'b1; b1.flush = 1'b0;
    b2.req_valid = 1'b0; b2.req_addr = '0; b2.rsp_ready = 1'b1; b2.flush = 1'b0;

    // ---- reset state (rst still high, a request offered) ----
    tick();
    tick();
    b1.req_valid = 1'b1;
    b2.req_valid = 1'b1;
    #1;
    check("rst_l1_rsp_valid", b1.rsp_valid, 0);
    check("rst_l1_rsp_data",  b1.rsp_data,  0);
    check("rst_l1_rsp_err",   b1.rsp_err,   0);
    check("rst_l1_req_ready", b1.req_ready, 0);
    check("rst_l2_rsp_valid", b2.rsp_valid, 0);
    check("rst_l2_rsp_data",  b2.rsp_data,  0);
    check("rst_l2_req_ready", b2.req_ready, 0);
    b1.req_valid = 1'b0;
    b2.req_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_l1_req_ready", b1.req_ready, 1);
    check("post_rst_l2_req_ready", b2.req_ready, 1);
    tick();

    // ---- program preload ----
`ifdef INST_ROM_LOAD_EN
    for (int i = 0; i < DEPTH; i++) begin
      ld_we   = 1'b1;
      ld_addr = 6'(i);
      ld_data = model[i];
      tick();
    end
    ld_we = 1'b0;
`else
    for (int i = 0; i < DEPTH; i++) begin
      dut1.mem_q[i] <= model[i];
      dut2.mem_q[i] <= model[i];
    end
`endif
    tick();

    // ---- streaming fetch, out-of-range, misaligned, boundaries (LATENCY=1) ----
    for (int i = 0; i <= 8; i++) begin
      b1.req_valid = (i < 8);
      b1.req_addr  = (i < 8) ? s_addr[i] : 32'h0;
      #1;
      if (i < 8) check($sformatf("stream%0d_req_ready", i), b1.req_ready, 1);
      if (i > 0) begin
        check($sformatf("stream%0d_rsp_valid", i - 1), b1.rsp_valid, 1);
        check($sformatf("stream%0d_rsp_data", i - 1),  b1.rsp_data,  s_data[i-1]);
        check($sformatf("stream%0d_rsp_err", i - 1),   b1.rsp_err,   32'(s_err[i-1]));
      end
      tick();
    end
    #1;
    check("stream_idle_rsp_valid", b1.rsp_valid, 0);
    tick();

    // ---- flush during stall on LATENCY=1: flush wins ----
    b1.req_valid = 1'b1;
    b1.req_addr  = 32'h10;
    tick();
    b1.req_valid = 1'b0;
    b1.rsp_ready = 1'b0;
    b1.flush     = 1'b1;
    #1;
    check("fstall_rsp_valid", b1.rsp_valid, 1);
    check("fstall_rsp_data",  b1.rsp_data,  model[4]);
    check("fstall_req_ready", b1.req_ready, 0);
    tick();
    b1.flush     = 1'b0;
    b1.rsp_ready = 1'b1;
    #1;
    check("fstall_after_rsp_valid", b1.rsp_valid, 0);
    check("fstall_after_req_ready", b1.req_ready, 1);
    tick();

    // ---- backpressure (LATENCY=2): four requests, 3-cycle stall ----
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      b2.rsp_ready = bp_rsp_ready[c];
      b2.req_valid = (sent < 4);
      b2.req_addr  = 32'h10 + 32'(sent) * 32'd4;
      #1;
      check($sformatf("bp%0d_req_ready", c), b2.req_ready, 32'(bp_exp_rr[c]));
      check($sformatf("bp%0d_rsp_valid", c), b2.rsp_valid, 32'(bp_exp_rv[c]));
      if (bp_exp_word[c] >= 0) begin
        check($sformatf("bp%0d_rsp_data", c), b2.rsp_data, model[bp_exp_word[c]]);
        check($sformatf("bp%0d_rsp_err", c),  b2.rsp_err,  0);
      end
      if (b2.req_valid && b2.req_ready) sent++;
      tick();
    end
    check("bp_all_sent", sent, 4);
    b2.req_valid = 1'b0;
    b2.rsp_ready = 1'b1;

    // ---- flush with two in flight plus one accepted (LATENCY=2) ----
    b2.req_valid = 1'b1;
    b2.req_addr  = 32'h20;
    tick();
    b2.req_addr  = 32'h24;
    #1;
    check("fl_c1_rsp_valid", b2.rsp_valid, 0);
    tick();
    b2.req_addr  = 32'h28;
    b2.flush     = 1'b1;
    #1;
    check("fl_c2_req_ready", b2.req_ready, 1);
    tick();
    b2.flush     = 1'b0;
    b2.req_valid = 1'b0;
    #1;
    check("fl_c3_rsp_valid", b2.rsp_valid, 0);
    tick();
    #1;
    check("fl_c4_rsp_valid", b2.rsp_valid, 0);
    tick();
    b2.req_valid = 1'b1;
    b2.req_addr  = 32'h2C;
    #1;
    check("fl_c5_rsp_valid", b2.rsp_valid, 0);
    tick();
    b2.req_valid = 1'b0;
    #1;
    check("fl_c6_rsp_valid", b2.rsp_valid, 0);
    tick();
    #1;
    check("fl_new_rsp_valid", b2.rsp_valid, 1);
    check("fl_new_rsp_data",  b2.rsp_data,  model[11]);
    tick();
    #1;
    check("fl_new_done", b2.rsp_valid, 0);
    tick();

    // ---- reset mid-stall (LATENCY=2), loader write blocked by reset ----
    b2.rsp_ready = 1'b0;
    b2.req_valid = 1'b1;
    b2.req_addr  = 32'h30;
    tick();
    b2.req_addr  = 32'h34;
    #1;
    check("rs_c1_req_ready", b2.req_ready, 1);
    tick();
    b2.req_valid = 1'b0;
    #1;
    check("rs_c2_rsp_valid", b2.rsp_valid, 1);
    check("rs_c2_rsp_data",  b2.rsp_data,  model[12]);
    check("rs_c2_req_ready", b2.req_ready, 0);
    tick();
    rst     = 1'b1;
    ld_we   = 1'b1;
    ld_addr = 6'd12;
    ld_data = 32'hFFFF_FFFF;
    #1;
    check("rs_c3_held_data", b2.rsp_data,  model[12]);
    check("rs_c3_l2_ready",  b2.req_ready, 0);
    check("rs_c3_l1_ready",  b1.req_ready, 0);
    tick();
    rst   = 1'b0;
    ld_we = 1'b0;
    #1;
    check("rs_c4_rsp_valid", b2.rsp_valid, 0);
    check("rs_c4_rsp_data",  b2.rsp_data,  0);
    check("rs_c4_rsp_err",   b2.rsp_err,   0);
    check("rs_c4_req_ready", b2.req_ready, 1);
    b2.rsp_ready = 1'b1;
    b2.req_valid = 1'b1;
    b2.req_addr  = 32'h30;
    tick();
    b2.req_valid = 1'b0;
    tick();
    #1;
    check("rs_mem_kept_valid", b2.rsp_valid, 1);
    check("rs_mem_kept_data",  b2.rsp_data,  model[12]);
    tick();

    // ---- loader read-before-write (LATENCY=1) ----
`ifdef INST_ROM_LOAD_EN
    exp_new = 32'hDEAD_BEEF;
`else
    exp_new = model[5];
`endif
    ld_we        = 1'b1;
    ld_addr      = 6'd5;
    ld_data      = 32'hDEAD_BEEF;
    b1.req_valid = 1'b1;
    b1.req_addr  = 32'h14;
    tick();
    ld_we = 1'b0;
    #1;
    check("ld_same_cycle_data", b1.rsp_data, model[5]);
    tick();
    b1.req_valid = 1'b0;
    #1;
    check("ld_next_cycle_valid", b1.rsp_valid, 1);
    check("ld_next_cycle_data",  b1.rsp_data,  exp_new);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
